ctrl_pipe_arbiter: RTL
======================

// Module: ctrl_pipe_arbiter
// PURPOSE
//  - Shares the single control-type execute pipe between NUM_REQ issue-lane requesters.
//  - Grants are round-robin, one per cycle.
//  - Serializes CSR instructions: a CSR op is granted only when the pipe is empty.
//    No further grant is issued until its CSR writeback completes.
//  - Sits between the issue-queue select logic and the control execute stage.
// PARAMETERS
//  - NUM_REQ   2   number of requesting issue lanes (2..4)
//  - INFL_W    3   width of the in-flight op counter; max in-flight = 2**INFL_W-1
//  - PERF_W    16  width of the optional performance counters
// PORTS
//  - clk              in   1        core clock, rising edge
//  - reset_n          in   1        asynchronous, active-low reset
//  - req_i            in   NUM_REQ  lane i has a control op ready; held until granted or flushed
//  - reqIsCSR_i       in   NUM_REQ  the op on lane i is a CSR instruction
//  - exeReady_i       in   1        control execute stage can accept an op this cycle
//  - wbValid_i        in   1        a non-CSR control op left writeback (decrements in-flight)
//  - csrDone_i        in   1        CSR writeback of the outstanding CSR op completed
//  - flush_i          in   1        pipeline flush (mispredict/exception)
//  - grant_o          out  NUM_REQ  registered one-hot grant, valid for exactly one cycle
//  - grantValid_o     out  1        OR of grant_o
//  - csrBusy_o        out  1        CSR serialization in progress (state != IDLE)
//  - perfConflict_o   out  PERF_W   (CTRL_ARB_PERF_EN only) cycles with >1 request pending
//  - perfCsrStall_o   out  PERF_W   (CTRL_ARB_PERF_EN only) cycles spent in CSR_DRAIN/CSR_EXEC
// BEHAVIOUR
//  - Reset values:
//    - grant_o=0, grantValid_o=0, csrBusy_o=0, state=IDLE.
//    - rrPtr=0, inFlight=0, perf counters=0.
//  - Grant latency: the grant decision is made in cycle N; grant_o is asserted in cycle N+1 for one cycle.
//  - Round-robin:
//    - Search starts at rrPtr and wraps modulo NUM_REQ.
//    - The first eligible lane wins, then rrPtr <= winner+1 (mod NUM_REQ).
//    - A non-granted cycle leaves rrPtr unchanged.
//  - A lane is eligible when all of the following hold:
//    - req_i[i]=1 and exeReady_i=1 and state==IDLE.
//    - It was not granted in the previous cycle (so a held req is not double-granted).
//  - In-flight accounting:
//    - A non-CSR grant increments inFlight; wbValid_i decrements it.
//    - Both in the same cycle: inFlight is unchanged.
//    - Saturated inFlight (all ones) blocks non-CSR grants.
//    - wbValid_i at inFlight=0 is ignored (no underflow).
//  - FSM:
//    - IDLE: the winner is a CSR op -> if inFlight==0, grant it and go to CSR_EXEC; else no grant, go to CSR_DRAIN.
//    - CSR_DRAIN: no grants; when inFlight==0 and exeReady_i=1, grant the pending CSR lane and go to CSR_EXEC.
//      The CSR lane is latched on entry, so rrPtr does not move while draining.
//    - CSR_EXEC: no grants; on csrDone_i go to IDLE. The next grant is possible in the cycle after returning.
//  - csrDone_i outside CSR_EXEC is ignored.
//  - flush_i has priority over every other input in the same cycle:
//    - next cycle: state=IDLE, grant_o=0, inFlight=0, latched CSR lane cleared.
//    - rrPtr is kept.
//    - A grant computed in the flush cycle is dropped.
//  - Reset asserted mid-operation forces all reset values asynchronously.
// CONFIGURATION
//  - CTRL_ARB_PERF_EN defined:
//    - perfConflict_o and perfCsrStall_o exist as PERF_W saturating counters.
//    - The counters are cleared only by reset; flush does not clear them.
//  - CTRL_ARB_PERF_EN undefined:
//    - Both ports and their counters are absent.
//    - Arbitration behaviour is identical cycle-for-cycle.
// TESTING
//  - Round-robin: NUM_REQ=2, req_i=2'b11 held, no CSR, exeReady_i=1 -> grants alternate 01,10,01...
//    with a one-cycle gap between grants per lane; rrPtr ends 0 after 4 grants.
//  - CSR drain: inFlight=2, lane0 CSR req -> no grant and csrBusy_o=1.
//    Then two wbValid_i pulses -> grant_o=01 the cycle after inFlight hits 0.
//    Lane1 is not granted until csrDone_i returns state to IDLE.
//  - Simultaneous events: wbValid_i together with a non-CSR grant -> inFlight unchanged.
//    wbValid_i at inFlight=0 -> stays 0.
//  - Flush: flush_i in CSR_DRAIN with req_i=11 -> next cycle state=IDLE, grant_o=00, inFlight=0.
//    Arbitration resumes from the unchanged rrPtr.
//  - Back-pressure: exeReady_i=0 for 5 cycles with req_i=01 -> no grant.
//    The first cycle after exeReady_i=1 -> grant_o=01 one cycle later.
//  - PERF (macro on): req_i=11 for 10 cycles -> perfConflict_o=10.
//    Reset mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_pipe_arbiter.sv
// Round-robin arbiter for the shared control execute pipe, with CSR serialization.
// Optional perf counters are compiled in when CTRL_ARB_PERF_EN is defined.
module ctrl_pipe_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int INFL_W  = 3,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] reqIsCSR_i,
  input  logic               exeReady_i,
  input  logic               wbValid_i,
  input  logic               csrDone_i,
  input  logic               flush_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grantValid_o,
  output logic               csrBusy_o
`ifdef CTRL_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]  perfConflict_o,
  output logic [PERF_W-1:0]  perfCsrStall_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, CSR_DRAIN, CSR_EXEC} state_t;

  state_t             r_state, w_nextState;
  logic [PTR_W-1:0]   r_rrPtr, w_rrNext;
  logic [PTR_W-1:0]   r_csrLane, w_csrNext;
  logic [INFL_W-1:0]  r_inFlight;
  logic [NUM_REQ-1:0] r_grant, w_grantVec, w_elig;
  logic [PTR_W-1:0]   w_win;
  logic               w_found, w_inc, w_dec, w_sat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_sat = &r_inFlight;
  assign w_dec = wbValid_i && (r_inFlight != '0);

  // A lane granted last cycle still shows its held request; exclude it.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_elig[i] = req_i[i] & exeReady_i & (r_state == IDLE) & ~r_grant[i]
                & (reqIsCSR_i[i] | ~w_sat);
  end

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rrPtr) + k) % NUM_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_grantVec  = '0;
    w_nextState = r_state;
    w_rrNext    = r_rrPtr;
    w_csrNext   = r_csrLane;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          if (reqIsCSR_i[w_win]) begin
            if (r_inFlight == '0) begin
              w_grantVec[w_win] = 1'b1;
              w_rrNext          = ptr_inc(w_win);
              w_nextState       = CSR_EXEC;
            end else begin
              w_csrNext   = w_win;
              w_nextState = CSR_DRAIN;
            end
          end else begin
            w_grantVec[w_win] = 1'b1;
            w_rrNext          = ptr_inc(w_win);
            w_inc             = 1'b1;
          end
        end
      end
      CSR_DRAIN: begin
        if (r_inFlight == '0 && exeReady_i) begin
          w_grantVec[r_csrLane] = 1'b1;
          w_rrNext              = ptr_inc(r_csrLane);
          w_nextState           = CSR_EXEC;
        end
      end
      CSR_EXEC: if (csrDone_i) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_csrLane  <= '0;
      r_inFlight <= '0;
      r_grant    <= '0;
    end else if (flush_i) begin
      // Flush drops any grant decided this cycle but keeps the fairness pointer.
      r_state    <= IDLE;
      r_csrLane  <= '0;
      r_inFlight <= '0;
      r_grant    <= '0;
    end else begin
      r_state   <= w_nextState;
      r_rrPtr   <= w_rrNext;
      r_csrLane <= w_csrNext;
      r_grant   <= w_grantVec;
      if (w_inc && !w_dec)      r_inFlight <= r_inFlight + 1'b1;
      else if (!w_inc && w_dec) r_inFlight <= r_inFlight - 1'b1;
    end
  end

  assign grant_o      = r_grant;
  assign grantValid_o = |r_grant;
  assign csrBusy_o    = (r_state != IDLE);

`ifdef CTRL_ARB_PERF_EN
  logic [PERF_W-1:0] r_perfConflict, r_perfCsrStall;
  logic              w_multi;

  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt += int'(req_i[i]);
    w_multi = (cnt > 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perfConflict <= '0;
      r_perfCsrStall <= '0;
    end else begin
      if (w_multi && !(&r_perfConflict)) r_perfConflict <= r_perfConflict + 1'b1;
      if ((r_state != IDLE) && !(&r_perfCsrStall)) r_perfCsrStall <= r_perfCsrStall + 1'b1;
    end
  end

  assign perfConflict_o = r_perfConflict;
  assign perfCsrStall_o = r_perfCsrStall;
`endif

endmodule
